// File: rtl/prio_encoder_req8to3_if.sv
// ---------------------------------------------------------------------------
// prio_encoder_req8to3_if
//   Bundles the request/handshake signals of the sequential priority encoder.
//   Handshake: out_valid/out_ready follow strict valid/ready rules. A code
//   transfers at a rising edge where out_valid && out_ready. While out_valid
//   is high and out_ready is low, out_code is held stable. out_valid never
//   drops without a transfer, except on reset.
//
//   Signals (N request lines, W = $clog2(N) code bits):
//     req        master->slave  N  request events, bit i = event on line i
//     out_ready  master->slave  1  consumer accepts out_code this cycle
//     ovr_clr    master->slave  1  synchronous clear of the overrun flag
//     out_valid  slave->master  1  out_code holds an issued, unaccepted index
//     out_code   slave->master  W  binary index of the granted line
//     pending    slave->master  N  registered set of requests not yet issued
//     overrun    slave->master  1  sticky: event arrived on a pending line
//
//   Modports: master is the requester/consumer side; slave is the encoder.
// ---------------------------------------------------------------------------
interface prio_encoder_req8to3_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         out_ready;
    logic         ovr_clr;
    logic         out_valid;
    logic [W-1:0] out_code;
    logic [N-1:0] pending;
    logic         overrun;

    modport master (
        output req,
        output out_ready,
        output ovr_clr,
        input  out_valid,
        input  out_code,
        input  pending,
        input  overrun
    );

    modport slave (
        input  req,
        input  out_ready,
        input  ovr_clr,
        output out_valid,
        output out_code,
        output pending,
        output overrun
    );
endinterface

// File: rtl/prio_encoder_req8to3.sv
// ---------------------------------------------------------------------------
// prio_encoder_req8to3
//   Sequential priority encoder. Request events on N lines are merged into a
//   pending set. The highest set bit of the registered pending set is issued
//   as a binary index over a valid/ready handshake, one code per transfer.
//
//   Ports:
//     clk          in   1   clock, all state on the rising edge
//     rst_n        in   1   asynchronous active-low reset
//     bus          slave modport of prio_encoder_req8to3_if
//                   (req, out_ready, ovr_clr in; out_valid, out_code,
//                    pending, overrun out)
//     dbg_state_o  out  1   FSM state (0 = IDLE, 1 = VALID)
// ---------------------------------------------------------------------------
module prio_encoder_req8to3 #(
    parameter int N = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    prio_encoder_req8to3_if.slave       bus,
    output logic                        dbg_state_o
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] code_q, code_d;
    logic [N-1:0] pending_q, pending_d;
    logic         overrun_q, overrun_d;

    logic [W-1:0] win_idx;
    logic [N-1:0] grant;
    logic         any_pending;
    logic         load;
    logic         ovr_event;

    // Highest set bit of the registered pending set wins. Same-cycle req does
    // not take part; it only lands in pending at this edge.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                win_idx = W'(i);
            end
        end
    end

    assign any_pending = |pending_q;
    assign load        = ((state_q == IDLE) || bus.out_ready) && any_pending;

    always_comb begin
        grant = '0;
        if (load) begin
            grant[win_idx] = 1'b1;
        end
    end

    // An event on a line that stays pending is merged and therefore lost.
    // The granted line is excluded: its new event re-pends it (set wins).
    assign ovr_event = |(bus.req & pending_q & ~grant);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pending_d = (pending_q & ~grant) | bus.req;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.out_ready && !any_pending) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            code_d = win_idx;
        end

        // New overrun takes precedence over a clear at the same edge.
        if (ovr_event) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.out_valid = (state_q == VALID);
    assign bus.out_code  = code_q;
    assign bus.pending   = pending_q;
    assign bus.overrun   = overrun_q;
    assign dbg_state_o   = state_q;

endmodule
